wb_master_arb: RTL

Wishbone many-to-one master arbiter: MASTERS bus initiators (CPU data port, DMA, debug bridge) share one downstream Wishbone port feeding the slave address decoder. The grant is round-robin and locked for the full `cyc` of the winning master. A per-transfer timeout counter answers stalled strobes with an error pulse. It is the initiator-side counterpart of the slave-select decoder: that block fans one master out to many slaves; this block merges many masters into one.

---
 rtl/wb_master_arb_if.sv | 38 +++
 rtl/wb_master_arb.sv | 106 ++++++++++
 2 files changed

// File: rtl/wb_master_arb_if.sv
// Bus bundle for the Wishbone many-to-one arbiter.
// The master modport is the arbiter's own view; slave is the surrounding environment.
interface wb_master_arb_if #(
    parameter int MASTERS = 4,
    parameter int AW      = 28
);
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic [MASTERS-1:0]    m_cyc_i;
    logic [MASTERS-1:0]    m_stb_i;
    logic [MASTERS-1:0]    m_we_i;
    logic [MASTERS*AW-1:0] m_adr_i;
    logic [MASTERS*DW-1:0] m_dat_i;
    logic [MASTERS*SW-1:0] m_sel_i;
    logic [MASTERS-1:0]    m_ack_o;
    logic [MASTERS-1:0]    m_err_o;
    logic [DW-1:0]         m_dat_o;

    logic                  s_cyc_o;
    logic                  s_stb_o;
    logic                  s_we_o;
    logic [AW-1:0]         s_adr_o;
    logic [DW-1:0]         s_dat_o;
    logic [SW-1:0]         s_sel_o;
    logic                  s_ack_i;
    logic [DW-1:0]         s_dat_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );
endinterface

// File: rtl/wb_master_arb.sv
// Round-robin Wishbone arbiter merging MASTERS initiators onto one downstream port.
// Grant is held for the owner's whole cyc; stalled strobes are terminated with an error pulse.
module wb_master_arb #(
    parameter int MASTERS = 4,
    parameter int MW      = $clog2(MASTERS),
    parameter int AW      = 28,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_master_arb_if.master  bus
);
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] gnt, gnt_nxt;
    logic [MW-1:0] last, last_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [MW-1:0] pick;
    logic          stb_raw;
    logic          tmo;

    // Rotating priority: the first requester after the previous owner wins.
    always_comb begin
        int idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= MASTERS; i++) begin
            idx = (int'(last) + i) % MASTERS;
            if (!found && bus.m_cyc_i[idx]) begin
                pick  = MW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= MW'(MASTERS - 1);
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    assign bus.m_dat_o = bus.s_dat_i;

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        last_nxt    = last;
        tcnt_nxt    = '0;
        stb_raw     = 1'b0;
        tmo         = 1'b0;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;

        case (state)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    gnt_nxt   = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stb_raw = bus.m_stb_i[gnt];
                // Ack on the terminal-count cycle takes precedence over the error.
                tmo     = stb_raw && !bus.s_ack_i && (tcnt == TW'(TIMEOUT));

                bus.s_cyc_o      = bus.m_cyc_i[gnt];
                bus.s_stb_o      = stb_raw && !tmo;
                bus.s_we_o       = bus.m_we_i[gnt];
                bus.s_adr_o      = bus.m_adr_i[int'(gnt)*AW +: AW];
                bus.s_dat_o      = bus.m_dat_i[int'(gnt)*DW +: DW];
                bus.s_sel_o      = bus.m_sel_i[int'(gnt)*SW +: SW];
                bus.m_ack_o[gnt] = bus.s_ack_i;
                bus.m_err_o[gnt] = tmo;

                if (stb_raw && !bus.s_ack_i && !tmo)
                    tcnt_nxt = tcnt + TW'(1);

                if (!bus.m_cyc_i[gnt]) begin
                    last_nxt  = gnt;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
